// File: rtl/fetch_aligner_pkg.sv
// Definitions shared by the fetch realignment stage and the instruction decoder.
package fetch_aligner_pkg;

   localparam int         HW_W          = 16;
   localparam int         QUEUE_DEPTH   = 4;
   localparam logic [1:0] OPC_QUAD_FULL = 2'b11;

   typedef logic [HW_W-1:0] halfword_t;

   // Anything outside the full-width quadrant is a 16-bit instruction.
   function automatic logic is_compressed(input halfword_t hw);
      return hw[1:0] != OPC_QUAD_FULL;
   endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Four-entry halfword shift queue: pops from the head and appends after the
// surviving entries in the same cycle. Entries at or beyond count are stale.
module fetch_hw_queue
   import fetch_aligner_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic [1:0]  push_n,
   input  logic [31:0] push_data,
   input  logic [1:0]  pop_n,
   output logic [15:0] q0,
   output logic [15:0] q1,
   output logic [2:0]  count
);

   halfword_t  q       [QUEUE_DEPTH];
   halfword_t  shifted [QUEUE_DEPTH];
   halfword_t  q_next  [QUEUE_DEPTH];
   logic [2:0] base;

   always_comb begin
      case (pop_n)
         2'd1:    shifted = '{q[1], q[2], q[3], q[3]};
         2'd2:    shifted = '{q[2], q[3], q[3], q[3]};
         default: shifted = q;
      endcase
   end

   assign base = count - {1'b0, pop_n};

   // The lower pushed halfword lands right after the surviving entries.
   always_comb begin
      q_next = shifted;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (push_n != 2'd0 && 3'(i) == base) begin
            q_next[i] = push_data[15:0];
         end
         if (push_n == 2'd2 && 3'(i) == base + 3'd1) begin
            q_next[i] = push_data[31:16];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= 3'd0;
      end else begin
         count <= count + {1'b0, push_n} - {1'b0, pop_n};
      end
   end

   always_ff @(posedge clock) begin
      q <= q_next;
   end

   assign q0 = q[0];
   assign q1 = q[1];

endmodule

// File: rtl/fetch_aligner.sv
// Realigns word-aligned fetch data into whole instructions for the decoder,
// owning the fetch address and the halfword-granular instruction PC.
module fetch_aligner
   import fetch_aligner_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_fetch_req,
   output logic [31:0] o_fetch_addr,
   input  logic        i_fetch_valid,
   input  logic [31:0] i_fetch_data,
   input  logic        i_flush,
   input  logic [31:0] i_flush_pc,
   output logic [31:0] o_insn,
   output logic [31:0] o_insn_pc,
   output logic        o_insn_compressed,
   output logic        o_insn_valid,
   input  logic        i_insn_ready
);

   localparam logic [31:0] RESET_PC_HW = {RESET_PC[31:1], 1'b0};
   localparam logic [31:0] RESET_FADDR = {RESET_PC[31:2], 2'b00};

   logic [31:0] pc;
   logic [31:0] faddr;
   logic        skip_low;

   logic [15:0] q0;
   logic [15:0] q1;
   logic [2:0]  count;

   logic        head_compressed;
   logic        fetch_fire;
   logic        consume;
   logic [1:0]  push_n;
   logic [1:0]  pop_n;
   logic [31:0] push_data;
   logic        unused_flush_bit;

   assign unused_flush_bit = i_flush_pc[0];

   assign head_compressed = is_compressed(q0);

   assign o_insn_valid = !i_rst && !i_flush &&
                         (count >= 3'd2 || (count == 3'd1 && head_compressed));
   assign o_fetch_req  = !i_rst && !i_flush && count <= 3'd2;

   assign o_insn            = head_compressed ? {16'h0000, q0} : {q1, q0};
   assign o_insn_compressed = head_compressed;
   assign o_insn_pc         = i_rst ? RESET_PC_HW : pc;
   assign o_fetch_addr      = i_rst ? RESET_FADDR : faddr;

   assign fetch_fire = o_fetch_req && i_fetch_valid;
   assign consume    = o_insn_valid && i_insn_ready;

   // After a redirect to an odd halfword only the upper half of the word is kept.
   assign push_n    = !fetch_fire ? 2'd0 : (skip_low ? 2'd1 : 2'd2);
   assign push_data = skip_low ? {16'h0000, i_fetch_data[31:16]} : i_fetch_data;
   assign pop_n     = !consume ? 2'd0 : (head_compressed ? 2'd1 : 2'd2);

   fetch_hw_queue u_queue (
      .clock     (i_clk),
      .reset     (i_rst),
      .clear     (i_flush),
      .push_n    (push_n),
      .push_data (push_data),
      .pop_n     (pop_n),
      .q0        (q0),
      .q1        (q1),
      .count     (count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc       <= RESET_PC_HW;
         faddr    <= RESET_FADDR;
         skip_low <= RESET_PC[1];
      end else if (i_flush) begin
         pc       <= {i_flush_pc[31:1], 1'b0};
         faddr    <= {i_flush_pc[31:2], 2'b00};
         skip_low <= i_flush_pc[1];
      end else begin
         if (fetch_fire) begin
            faddr    <= faddr + 32'd4;
            skip_low <= 1'b0;
         end
         if (consume) begin
            pc <= pc + (head_compressed ? 32'd2 : 32'd4);
         end
      end
   end

endmodule

// File: doc/fetch_aligner.md
# fetch_aligner

Instruction realignment stage between the fetch port and the instruction decoder for C_EXTENSION builds. Consumes word-aligned 32-bit fetch data and buffers halfwords in a 4-entry queue. Presents one complete instruction per handshake to the decoder's 32-bit opcode input: 16-bit compressed instructions are zero-extended, and 32-bit instructions may straddle a word boundary. Owns the fetch address sequencing and the halfword-granular instruction PC, including redirects to halfword-aligned targets.

## Interface
- RESET_PC, 32'h00000000, PC of first instruction after reset; bit 0 ignored
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- o_fetch_req  out  1  fetch request for word at o_fetch_addr
- o_fetch_addr  out  32  word address of request; bits [1:0] always 00
- i_fetch_valid  in  1  fetch word available this cycle; transfer occurs when o_fetch_req && i_fetch_valid
- i_fetch_data  in  32  fetched word; halfword 0 in [15:0]
- i_flush  in  1  redirect request; highest priority
- i_flush_pc  in  32  redirect target; bit 0 ignored
- o_insn  out  32  instruction to decoder; {16'h0000, hw} when compressed
- o_insn_pc  out  32  PC of o_insn; bit 0 always 0
- o_insn_compressed  out  1  o_insn[1:0] != 2'b11
- o_insn_valid  out  1  o_insn, o_insn_pc and o_insn_compressed are valid
- i_insn_ready  in  1  consumer accepts; consumption occurs when o_insn_valid && i_insn_ready

## Operation
- State:
  - halfword queue q[0..3] with head at q[0]; count 0..4
  - pc (32, bit 0 zero)
  - faddr (32, bits [1:0] zero)
  - skip_low flag: the lower halfword of the next delivered word is discarded
- Head classification: q[0][1:0]==2'b11 means 32-bit, otherwise compressed. Encodings for 48-bit and longer instructions are treated as 32-bit.
- o_insn_valid = !i_flush && (count>=2 || (count==1 && q[0][1:0]!=2'b11)).
- o_insn:
  - {q[1],q[0]} when 32-bit
  - {16'h0000,q[0]} when compressed
- o_fetch_req = !i_rst && !i_flush && count<=2. The decision uses the registered count, so fetch is allowed even if the same-cycle consume would free more space.
- Fetch transfer, word at faddr:
  - appends {hi,lo} (2 halfwords), or only hi (1 halfword) when skip_low=1
  - then clears skip_low and sets faddr+=4
- Consume:
  - removes 1 halfword (compressed) or 2 halfwords (32-bit) from the head
  - pc += 2 or 4
- Simultaneous fetch and consume: the queue shifts out the consumed halfwords and appends the new ones in the same cycle. count_next = count + added − removed. It never exceeds 4.
- Flush, which overrides fetch and consume in the same cycle:
  - count←0, pc←{i_flush_pc[31:1],0}, faddr←{i_flush_pc[31:2],00}, skip_low←i_flush_pc[1]
  - fetch data presented in the flush cycle is dropped; no consume occurs
- Reset:
  - count←0, pc←RESET_PC&~1, faddr←RESET_PC&~3, skip_low←RESET_PC[1]
- Output values while i_rst is high: o_fetch_req=0, o_insn_valid=0, o_fetch_addr=RESET_PC&~3, o_insn_pc=RESET_PC&~1.
- Address arithmetic is modulo 2^32; pc and faddr wrap from 0xFFFFFFFC to 0 without special handling.
- Halfword ordering is little-endian: lower address maps to the lower halfword.

## Timing
- Everything is registered except the combinational output derivations above. No combinational path from i_fetch_* to o_insn*.
- Latency: a word accepted in cycle N makes its first instruction valid in cycle N+1, provided the instruction is complete.
- A 32-bit instruction straddling words, or the first instruction after a halfword-aligned redirect, needs both words. It becomes valid in the cycle after the second word's transfer.
- Throughput:
  - aligned 32-bit stream: 1 instruction/cycle with fetch every cycle
  - compressed stream: 1 instruction/cycle, with fetch stalling in alternate cycles once count>2
- Flush in cycle N: o_insn_valid=0 in N and N+1; earliest fetch transfer in N+1; earliest valid instruction in N+2.
- Consumer back-pressure (i_insn_ready=0): outputs are held stable; fetch continues until count>2.

## Structure
- Shared package, also used by the decoder:
  - HW_W=16
  - QUEUE_DEPTH=4
  - OPC_QUAD_FULL=2'b11
  - compressed-detect function
- Sub-module fetch_hw_queue: a 4-entry halfword shift queue with inputs push_n (0/1/2), push_data[31:0], pop_n (0/1/2), clear. It outputs q0, q1 and count. The top level holds pc, faddr, skip_low and the handshake logic.

## Test plan
- Reset with RESET_PC=0, fetch words 0x00000013 and 0x00100093 at 0x0 and 0x4, ready=1: o_insn=0x00000013 with pc 0x0, then 0x00100093 with pc 0x4, on consecutive cycles starting the cycle after the first transfer.
- Word 0x45014501 (two c.li) at 0x0: o_insn=0x00004501 with pc 0x0, then pc 0x2, compressed=1. o_fetch_req drops while count>2.
- Mixed stream: c.nop 0x0001 at 0x0, then 32-bit 0x00500113 at 0x2 split across words 0x01130001 and 0x????0050. The second instruction is valid only after the second transfer, with o_insn=0x00500113 and pc 0x2.
- Flush to 0x106 while the queue is full and i_fetch_valid=1:
  - valid=0 for two cycles
  - next request address 0x104
  - lower halfword of that word discarded
  - first output pc 0x106
- i_insn_ready=0 for 5 cycles with a continuous fetch supply: count saturates at 4, o_fetch_req=0, o_insn is stable. After release, no instruction is lost or duplicated.
- Assert i_rst mid-stream with the queue partially full: the next cycle has count 0, valid=0 and fetch_addr=RESET_PC&~3. The stream restarts correctly.
